// File: rtl/serial_word_arbiter.sv
// Round-robin arbiter that grants one of two serial requesters at a time.
// It assembles WIDTH bits LSB-first and presents the word with a valid/ack handshake.
module serial_word_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic [1:0]       ireq,
    input  logic             isenal0,
    input  logic             isenal1,
    output logic [1:0]       ognt,
    output logic [WIDTH-1:0] oValor,
    output logic             oSrc,
    output logic             ovalid,
    input  logic             iack,
    output logic             obusy
);
    // state | meaning
    // IDLE  | no grant; arbitrate among pending requests
    // SHIFT | granted requester supplies one bit per cycle
    // HOLD  | completed word presented, waiting for iack
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t           state;
    logic             ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             win;
    logic             sbit;
    logic [WIDTH-1:0] word_nxt;

    // Pointer only matters when both requesters ask at once
    always_comb begin
        win = ireq[1];
        if (ireq == 2'b11) begin
            win = ptr;
        end
        sbit = ognt[1] ? isenal1 : isenal0;
        word_nxt = shreg;
        word_nxt[cnt] = sbit;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            cnt    <= '0;
            shreg  <= '0;
            ognt   <= 2'b00;
            oValor <= '0;
            oSrc   <= 1'b0;
            ovalid <= 1'b0;
            obusy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq != 2'b00) begin
                        ognt  <= win ? 2'b10 : 2'b01;
                        ptr   <= ~win;
                        cnt   <= '0;
                        obusy <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= word_nxt;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        oValor <= word_nxt;
                        oSrc   <= ognt[1];
                        ovalid <= 1'b1;
                        ognt   <= 2'b00;
                        cnt    <= '0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (iack) begin
                        ovalid <= 1'b0;
                        obusy  <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_arbiter.sv
// Self-checking bench for serial_word_arbiter: directed scenarios plus randomized
// traffic, compared every cycle against a word-level reference model.
module tb_serial_word_arbiter;
    logic       iclk    = 1'b0;
    logic       irst_n  = 1'b1;
    logic [1:0] ireq    = 2'b00;
    logic       isenal0 = 1'b0;
    logic       isenal1 = 1'b0;
    logic       iack    = 1'b0;
    logic [1:0] ognt;
    logic [7:0] oValor;
    logic       oSrc;
    logic       ovalid;
    logic       obusy;

    int checks = 0;
    int errors = 0;

    serial_word_arbiter #(.WIDTH(8)) dut (
        .iclk(iclk), .irst_n(irst_n), .ireq(ireq), .isenal0(isenal0), .isenal1(isenal1),
        .ognt(ognt), .oValor(oValor), .oSrc(oSrc), .ovalid(ovalid), .iack(iack), .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial sources: each presents its word LSB-first while granted
    bit         rand_words = 1'b0;
    logic [7:0] src_word [2];
    int         src_idx  [2];
    logic [1:0] prev_gnt = 2'b00;

    always @(negedge iclk) begin
        for (int n = 0; n < 2; n++) begin
            if (ognt[n]) begin
                if (!prev_gnt[n]) begin
                    src_idx[n] = 0;
                    if (rand_words) src_word[n] = 8'($urandom);
                end
                if (n == 0) isenal0 = src_word[0][src_idx[0]];
                else        isenal1 = src_word[1][src_idx[1]];
                src_idx[n]++;
            end
        end
        prev_gnt = ognt;
    end

    // Reference model: tracks owner, bits collected and handshake at word level
    int         m_owner;
    int         m_nbits;
    bit         m_hold;
    bit         m_ptr;
    logic [7:0] m_acc;
    logic [1:0] e_gnt;
    logic [7:0] e_val;
    logic       e_src, e_valid, e_busy;

    always @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            m_owner = -1; m_nbits = 0; m_hold = 0; m_ptr = 0; m_acc = 0;
            e_gnt = 0; e_val = 0; e_src = 0; e_valid = 0; e_busy = 0;
        end else if (m_hold) begin
            if (iack) begin
                e_valid = 0; e_busy = 0; m_hold = 0;
            end
        end else if (m_owner >= 0) begin
            m_acc[m_nbits] = (m_owner == 0) ? isenal0 : isenal1;
            m_nbits++;
            if (m_nbits == 8) begin
                e_val = m_acc; e_src = m_owner[0]; e_valid = 1; e_gnt = 0;
                m_owner = -1; m_hold = 1;
            end
        end else if (ireq != 2'b00) begin
            m_owner = (ireq == 2'b11) ? int'(m_ptr) : int'(ireq[1]);
            m_ptr = (m_owner == 0);
            m_nbits = 0;
            e_gnt = (m_owner == 0) ? 2'b01 : 2'b10;
            e_busy = 1;
        end
    end

    always @(negedge iclk) begin
        check("ognt", 32'(ognt), 32'(e_gnt));
        check("oValor", 32'(oValor), 32'(e_val));
        check("oSrc", 32'(oSrc), 32'(e_src));
        check("ovalid", 32'(ovalid), 32'(e_valid));
        check("obusy", 32'(obusy), 32'(e_busy));
    end

    task automatic check_zero(input string tag);
        check({tag, "_ognt"}, 32'(ognt), 32'd0);
        check({tag, "_oValor"}, 32'(oValor), 32'd0);
        check({tag, "_oSrc"}, 32'(oSrc), 32'd0);
        check({tag, "_ovalid"}, 32'(ovalid), 32'd0);
        check({tag, "_obusy"}, 32'(obusy), 32'd0);
    endtask

    // Called just after a negedge; reset is asserted and released between edges
    task automatic pulse_reset();
        #2 irst_n = 1'b0;
        ireq = 2'b00;
        #1 check_zero("rst_pulse");
        #1 irst_n = 1'b1;
    endtask

    task automatic wait_gnt(input logic [1:0] g);
        int k = 0;
        while (ognt != g && k < 40) begin
            @(negedge iclk);
            k++;
        end
        check("wait_gnt_timeout", 32'(ognt), 32'(g));
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!ovalid && k < 40) begin
            @(negedge iclk);
            k++;
        end
        check("wait_valid_timeout", 32'(ovalid), 32'd1);
    endtask

    task automatic ack_word();
        iack = 1'b1;
        @(negedge iclk);
        check("ack_clears_valid", 32'(ovalid), 32'd0);
        iack = 1'b0;
    endtask

    initial begin
        int         n;
        int         k;
        int         cyc;
        int         t_word [4];
        logic [7:0] v_word [4];
        logic       s_word [4];

        src_word[0] = 8'h00; src_word[1] = 8'h00;
        src_idx[0] = 0; src_idx[1] = 0;

        // Asynchronous reset with no clock edge
        #2 irst_n = 1'b0;
        #1 check_zero("rst_async");
        repeat (3) @(negedge iclk);
        check_zero("rst_hold");
        irst_n = 1'b1;
        @(negedge iclk);

        // Single word from ch0
        src_word[0] = 8'hA5;
        ireq = 2'b01;
        wait_gnt(2'b01);
        ireq = 2'b00;
        n = 1;
        while (ognt == 2'b01 && n < 20) begin
            @(negedge iclk);
            if (ognt == 2'b01) n++;
        end
        check("single_gnt_cycles", 32'(n), 32'd8);
        check("single_valid", 32'(ovalid), 32'd1);
        check("single_value", 32'(oValor), 32'hA5);
        check("single_src", 32'(oSrc), 32'd0);
        ack_word();

        // Contention with iack tied high
        pulse_reset();
        @(negedge iclk);
        src_word[0] = 8'h3C; src_word[1] = 8'hC3;
        ireq = 2'b11;
        iack = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 80) begin
            @(negedge iclk);
            cyc++;
            if (ovalid) begin
                t_word[k] = cyc; v_word[k] = oValor; s_word[k] = oSrc;
                k++;
            end
        end
        ireq = 2'b00;
        check("cont_words", 32'(k), 32'd4);
        for (int i = 0; i < k; i++) begin
            check("cont_value", 32'(v_word[i]), (i % 2 == 0) ? 32'h3C : 32'hC3);
            check("cont_src", 32'(s_word[i]), 32'(i % 2));
            if (i > 0) check("cont_period", 32'(t_word[i] - t_word[i-1]), 32'd10);
        end
        @(negedge iclk);
        iack = 1'b0;
        repeat (2) @(negedge iclk);

        // Stall: consumer holds off for 5 cycles while ch1 waits
        src_word[0] = 8'h5A; src_word[1] = 8'h69;
        ireq = 2'b01;
        wait_valid();
        ireq = 2'b10;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(ovalid), 32'd1);
            check("stall_value", 32'(oValor), 32'h5A);
            check("stall_gnt", 32'(ognt), 32'd0);
            check("stall_busy", 32'(obusy), 32'd1);
            @(negedge iclk);
        end
        iack = 1'b1;
        @(negedge iclk);
        iack = 1'b0;
        check("stall_released", 32'(ovalid), 32'd0);
        check("stall_idle_gnt", 32'(ognt), 32'd0);
        @(negedge iclk);
        check("stall_next_gnt", 32'(ognt), 32'b10);
        ireq = 2'b00;
        wait_valid();
        check("stall_ch1_value", 32'(oValor), 32'h69);
        ack_word();

        // Reset in the middle of a word, then pointer must be back at ch0
        src_word[0] = 8'hF0;
        ireq = 2'b01;
        wait_gnt(2'b01);
        repeat (4) @(negedge iclk);
        pulse_reset();
        @(negedge iclk);
        check_zero("rst_midword");
        src_word[0] = 8'hFF; src_word[1] = 8'h00;
        ireq = 2'b11;
        wait_valid();
        ireq = 2'b00;
        check("after_rst_value", 32'(oValor), 32'hFF);
        check("after_rst_src", 32'(oSrc), 32'd0);
        ack_word();
        repeat (12) @(negedge iclk);

        // iack in IDLE and SHIFT is ignored; ireq drop mid-word does not revoke
        iack = 1'b1;
        @(negedge iclk);
        iack = 1'b0;
        check("idle_ack_ignored", 32'(ovalid), 32'd0);
        src_word[0] = 8'h96;
        ireq = 2'b01;
        wait_gnt(2'b01);
        repeat (3) @(negedge iclk);
        ireq = 2'b00;
        iack = 1'b1;
        @(negedge iclk);
        iack = 1'b0;
        check("drop_keeps_gnt", 32'(ognt), 32'b01);
        wait_valid();
        check("drop_value", 32'(oValor), 32'h96);
        check("drop_src", 32'(oSrc), 32'd0);
        ack_word();

        // Randomized traffic with occasional asynchronous resets
        rand_words = 1'b1;
        repeat (3000) begin
            @(negedge iclk);
            ireq = 2'($urandom);
            iack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) pulse_reset();
        end
        ireq = 2'b00;
        iack = 1'b0;
        repeat (2) @(negedge iclk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
